end_screen_reader: RTL and testbench
====================================

Name: end_screen_reader

Overview:
- Read-side initiator for the 4-bit-per-pixel end-screen image ROM (224x256 pixels, 57344 entries, one-cycle registered read latency).
- On a start pulse it walks a rectangular window of the image in row-major order and drives ROM addresses.
- It absorbs the ROM latency and streams palette indices to a downstream consumer (frame-buffer writer or line buffer) over a valid/ready handshake with full backpressure.
- It sits between the end-screen ROM and the video compositing path.

Parameters:
- IMG_W, 224, image width in pixels (ROM row stride)
- IMG_H, 256, image height in pixels
- ADDR_W, 16, ROM address width
- PIX_W, 4, palette index width
- FIFO_DEPTH, 4, output buffer entries (power of two, >= 3)

Ports:
- Clk  in  1  system clock, all state on rising edge
- Reset_n  in  1  asynchronous active-low reset
- start  in  1  one-cycle request; accepted only in IDLE
- abort  in  1  synchronous flush to IDLE
- win_x  in  8  window left column, 0..IMG_W-1
- win_y  in  8  window top row, 0..IMG_H-1
- win_w  in  8  window width in pixels
- win_h  in  9  window height in rows, 0..256
- busy  out  1  high from the edge that accepts start until the done edge
- done  out  1  one-cycle pulse after the final pixel handshake
- read_address  out  ADDR_W  ROM address, registered
- rom_data  in  PIX_W  ROM data_Out; valid one cycle after read_address
- pix_valid  out  1  output pixel available
- pix_ready  in  1  consumer accepts when pix_valid && pix_ready
- pix_data  out  PIX_W  palette index
- pix_eol  out  1  pixel is the last in its window row
- pix_eof  out  1  pixel is the last in the window

Behaviour:
- Reset (asynchronous, Reset_n low):
  - busy, done, pix_valid, pix_eol, pix_eof = 0.
  - read_address = 0, pix_data = 0.
  - FIFO empty, FSM = IDLE, in-flight count = 0.
- FSM states: IDLE, RUN, DRAIN, FINISH.
  - IDLE -> RUN on start. Latch the window with clipping: eff_w = min(win_w, IMG_W-win_x), eff_h = min(win_h, IMG_H-win_y). row_base = win_y*IMG_W. col = 0, row = 0.
  - IDLE -> FINISH on start if eff_w==0 or eff_h==0. No address is issued and no pixel is emitted.
  - RUN: issue one address per cycle when fifo_count + inflight < FIFO_DEPTH. The simultaneous pop is not credited.
    - read_address <= row_base + win_x + col on the issuing edge.
    - col wraps at eff_w-1 to 0, then row++ and row_base += IMG_W. There is no multiply after start.
    - RUN -> DRAIN on the edge that issues the last address.
  - DRAIN -> FINISH when inflight==0 and the FIFO-empty edge pops the eof pixel.
  - FINISH: done=1 for exactly one cycle; busy drops on the same edge; next state IDLE.
- read_address holds its value when not issuing. Re-reading is harmless.
- Latency path:
  - Address register at edge E.
  - ROM data at E+1.
  - FIFO write at E+2. A 2-stage in-flight tag pipeline carries eol/eof alongside.
  - With start sampled at edge 0 and pix_ready=1, pix_valid is first high after edge 3. Steady state is 1 pixel/clk.
- Output handshake:
  - pix_valid, pix_data, pix_eol, pix_eof are driven from the FIFO head.
  - They are stable while pix_valid && !pix_ready.
  - No pixel is dropped or duplicated under any ready pattern.
- start while busy: ignored, no effect.
- abort: in any state, on the next edge FIFO and in-flight are discarded, FSM = IDLE, busy = 0, no done pulse. abort has priority over start in the same cycle.
- Reset mid-operation: immediate asynchronous return to reset values. A partial frame is never resumed.
- Address bound: maximum issued address is 57343, which fits in 16 bits. The clipping guarantees no address >= IMG_W*IMG_H.

Decomposition:
- Package sprite_rom_pkg holds IMG_W, IMG_H, PIX_W, ADDR_W, the FSM state enum, and a pixel-tag struct {data, eol, eof}.
- Sub-module pix_fifo: synchronous FIFO of tag structs, FIFO_DEPTH entries, with count output, push/pop, and synchronous flush.

Test Plan:
- Full frame: start with window (0,0,224,256), pix_ready=1 constantly.
  - Response: 57344 pixels in address order, matching the ROM image file.
  - eol every 224th pixel; eof on pixel 57344.
  - done 1 cycle after the eof handshake; first pix_valid after edge 3.
- Small window: start with window (10,20,3,2).
  - Addresses issued: 4490, 4491, 4492, 4714, 4715, 4716.
  - eol on pixels 3 and 6; eof on pixel 6.
- Backpressure: 8x8 window with pix_ready toggling 1,0,0,1 repeating.
  - Response: exactly 64 pixels in order, none lost or duplicated.
  - Outputs stable while stalled; at most FIFO_DEPTH addresses outstanding.
- Clipping and empty window:
  - Window (220,250,10,10): 4x6 = 24 pixels, last address 57343.
  - win_w=0: done the cycle after start, zero pixels, busy one cycle.
- Abort and reset mid-run:
  - abort after 100 pixels: busy 0 next cycle, pix_valid 0, no done; a new start then restarts at the window origin.
  - Reset_n pulsed low mid-frame: outputs go to reset values without waiting for a clock edge.

Source files
------------

// File: rtl/sprite_rom_pkg.sv
// Shared constants and types for the end-screen image ROM reader.
package sprite_rom_pkg;

   localparam int IMG_W  = 224;
   localparam int IMG_H  = 256;
   localparam int PIX_W  = 4;
   localparam int ADDR_W = 16;

   typedef enum logic [1:0] {
      IDLE,
      RUN,
      DRAIN,
      FINISH
   } state_e;

   typedef struct packed {
      logic [PIX_W-1:0] data;
      logic             eol;
      logic             eof;
   } pix_tag_t;

   // Length of a window span after clipping against the image edge.
   function automatic logic [9:0] clip_len(input logic [9:0] req,
                                           input logic [9:0] origin,
                                           input logic [9:0] limit);
      logic [9:0] avail;
      avail = (origin < limit) ? (limit - origin) : '0;
      return (req < avail) ? req : avail;
   endfunction

endpackage

// File: rtl/end_screen_reader_if.sv
// Pixel stream from the end-screen reader to its downstream consumer.
interface end_screen_reader_if #(
   parameter int PIX_W = sprite_rom_pkg::PIX_W
);
   logic             pix_valid;
   logic             pix_ready;
   logic [PIX_W-1:0] pix_data;
   logic             pix_eol;
   logic             pix_eof;

   modport master (
      output pix_valid,
      output pix_data,
      output pix_eol,
      output pix_eof,
      input  pix_ready
   );

   modport slave (
      input  pix_valid,
      input  pix_data,
      input  pix_eol,
      input  pix_eof,
      output pix_ready
   );
endinterface

// File: rtl/pix_fifo.sv
// Show-ahead FIFO of pixel tags with occupancy count and synchronous flush.
module pix_fifo
   import sprite_rom_pkg::*;
#(
   parameter int DEPTH = 4,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             Clk,
   input  logic             Reset_n,
   input  logic             flush,
   input  logic             push,
   input  pix_tag_t         push_tag,
   input  logic             pop,
   output pix_tag_t         head_tag,
   output logic [CNT_W-1:0] count
);
   localparam int PTR_W = $clog2(DEPTH);

   pix_tag_t         mem_q [DEPTH];
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [CNT_W-1:0] count_q, count_d;
   logic             do_push, do_pop;

   always_comb begin
      do_pop   = pop && (count_q != '0);
      do_push  = push && ((count_q != CNT_W'(DEPTH)) || do_pop);
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      count_d  = count_q;
      if (flush) begin
         do_push  = 1'b0;
         do_pop   = 1'b0;
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end else begin
         if (do_push) begin
            wr_ptr_d = wr_ptr_q + PTR_W'(1);
         end
         if (do_pop) begin
            rd_ptr_d = rd_ptr_q + PTR_W'(1);
         end
         count_d = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         wr_ptr_q <= '0;
         rd_ptr_q <= '0;
         count_q  <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         count_q  <= count_d;
      end
   end

   always_ff @(posedge Clk) begin
      if (do_push) begin
         mem_q[wr_ptr_q] <= push_tag;
      end
   end

   assign head_tag = mem_q[rd_ptr_q];
   assign count    = count_q;

endmodule

// File: rtl/end_screen_reader.sv
// Walks a clipped window of the end-screen ROM in row-major order and streams
// palette indices with eol/eof markers over a valid/ready interface.
module end_screen_reader #(
   parameter int IMG_W      = sprite_rom_pkg::IMG_W,
   parameter int IMG_H      = sprite_rom_pkg::IMG_H,
   parameter int ADDR_W     = sprite_rom_pkg::ADDR_W,
   parameter int PIX_W      = sprite_rom_pkg::PIX_W,
   parameter int FIFO_DEPTH = 4
) (
   input  logic                Clk,
   input  logic                Reset_n,
   input  logic                start,
   input  logic                abort,
   input  logic [7:0]          win_x,
   input  logic [7:0]          win_y,
   input  logic [7:0]          win_w,
   input  logic [8:0]          win_h,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   read_address,
   input  logic [PIX_W-1:0]    rom_data,
   end_screen_reader_if.master pix
);
   import sprite_rom_pkg::*;

   localparam int CNT_W = $clog2(FIFO_DEPTH) + 1;

   state_e            state_q, state_d;
   logic [7:0]        x_q, x_d;
   logic [9:0]        eff_w_q, eff_w_d;
   logic [9:0]        eff_h_q, eff_h_d;
   logic [9:0]        col_q, col_d;
   logic [9:0]        row_q, row_d;
   logic [ADDR_W-1:0] row_base_q, row_base_d;
   logic [ADDR_W-1:0] read_address_q, read_address_d;
   logic              s1_valid_q, s1_valid_d;
   logic              s1_eol_q, s1_eol_d;
   logic              s1_eof_q, s1_eof_d;
   logic              s2_valid_q, s2_valid_d;
   logic              s2_eol_q, s2_eol_d;
   logic              s2_eof_q, s2_eof_d;

   logic [9:0]        clip_w, clip_h;
   logic [CNT_W-1:0]  fifo_count, inflight;
   logic              can_issue, last_col, last_row;
   logic              fifo_push, fifo_pop, fifo_flush;
   logic              pix_valid_w;
   pix_tag_t          push_tag, head_tag;

   assign clip_w = clip_len(10'(win_w), 10'(win_x), 10'(IMG_W));
   assign clip_h = clip_len(10'(win_h), 10'(win_y), 10'(IMG_H));

   // Credit counts the FIFO plus both in-flight stages; a same-cycle pop is
   // deliberately not credited so the FIFO can never overflow.
   assign inflight  = CNT_W'(s1_valid_q) + CNT_W'(s2_valid_q);
   assign can_issue = (fifo_count + inflight) < CNT_W'(FIFO_DEPTH);

   assign pix_valid_w = (fifo_count != '0);
   assign fifo_pop    = pix_valid_w && pix.pix_ready;
   assign fifo_push   = s2_valid_q;

   always_comb begin
      push_tag      = '0;
      push_tag.data = rom_data;
      push_tag.eol  = s2_eol_q;
      push_tag.eof  = s2_eof_q;
   end

   always_comb begin
      state_d        = state_q;
      x_d            = x_q;
      eff_w_d        = eff_w_q;
      eff_h_d        = eff_h_q;
      col_d          = col_q;
      row_d          = row_q;
      row_base_d     = row_base_q;
      read_address_d = read_address_q;
      s1_valid_d     = 1'b0;
      s1_eol_d       = 1'b0;
      s1_eof_d       = 1'b0;
      s2_valid_d     = s1_valid_q;
      s2_eol_d       = s1_eol_q;
      s2_eof_d       = s1_eof_q;
      fifo_flush     = 1'b0;
      last_col       = (col_q == eff_w_q - 10'd1);
      last_row       = (row_q == eff_h_q - 10'd1);

      case (state_q)
         IDLE: begin
            if (start) begin
               x_d        = win_x;
               eff_w_d    = clip_w;
               eff_h_d    = clip_h;
               col_d      = '0;
               row_d      = '0;
               row_base_d = ADDR_W'(32'(win_y) * 32'(IMG_W));
               state_d    = ((clip_w == '0) || (clip_h == '0)) ? FINISH : RUN;
            end
         end
         RUN: begin
            if (can_issue) begin
               read_address_d = row_base_q + ADDR_W'(x_q) + ADDR_W'(col_q);
               s1_valid_d     = 1'b1;
               s1_eol_d       = last_col;
               s1_eof_d       = last_col && last_row;
               if (last_col) begin
                  col_d      = '0;
                  row_d      = row_q + 10'd1;
                  row_base_d = row_base_q + ADDR_W'(IMG_W);
                  if (last_row) begin
                     state_d = DRAIN;
                  end
               end else begin
                  col_d = col_q + 10'd1;
               end
            end
         end
         DRAIN: begin
            if (fifo_pop && head_tag.eof && (inflight == '0)) begin
               state_d = FINISH;
            end
         end
         FINISH: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      // Abort discards everything queued and beats any start in the same cycle.
      if (abort) begin
         state_d        = IDLE;
         read_address_d = read_address_q;
         s1_valid_d     = 1'b0;
         s2_valid_d     = 1'b0;
         fifo_flush     = 1'b1;
      end
   end

   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q        <= IDLE;
         x_q            <= '0;
         eff_w_q        <= '0;
         eff_h_q        <= '0;
         col_q          <= '0;
         row_q          <= '0;
         row_base_q     <= '0;
         read_address_q <= '0;
         s1_valid_q     <= 1'b0;
         s1_eol_q       <= 1'b0;
         s1_eof_q       <= 1'b0;
         s2_valid_q     <= 1'b0;
         s2_eol_q       <= 1'b0;
         s2_eof_q       <= 1'b0;
      end else begin
         state_q        <= state_d;
         x_q            <= x_d;
         eff_w_q        <= eff_w_d;
         eff_h_q        <= eff_h_d;
         col_q          <= col_d;
         row_q          <= row_d;
         row_base_q     <= row_base_d;
         read_address_q <= read_address_d;
         s1_valid_q     <= s1_valid_d;
         s1_eol_q       <= s1_eol_d;
         s1_eof_q       <= s1_eof_d;
         s2_valid_q     <= s2_valid_d;
         s2_eol_q       <= s2_eol_d;
         s2_eof_q       <= s2_eof_d;
      end
   end

   pix_fifo #(
      .DEPTH (FIFO_DEPTH),
      .CNT_W (CNT_W)
   ) u_fifo (
      .Clk      (Clk),
      .Reset_n  (Reset_n),
      .flush    (fifo_flush),
      .push     (fifo_push),
      .push_tag (push_tag),
      .pop      (fifo_pop),
      .head_tag (head_tag),
      .count    (fifo_count)
   );

   assign read_address  = read_address_q;
   assign busy          = (state_q != IDLE);
   assign done          = (state_q == FINISH);
   assign pix.pix_valid = pix_valid_w;
   assign pix.pix_data  = pix_valid_w ? head_tag.data : '0;
   assign pix.pix_eol   = pix_valid_w && head_tag.eol;
   assign pix.pix_eof   = pix_valid_w && head_tag.eof;

endmodule

// File: tb/tb_end_screen_reader.sv
// Directed bench for end_screen_reader with a registered ROM model and a
// per-window scoreboard derived from the window geometry.
module tb_end_screen_reader;

   logic        Clk = 1'b0;
   logic        Reset_n;
   logic        start;
   logic        abort;
   logic [7:0]  win_x, win_y, win_w;
   logic [8:0]  win_h;
   logic        busy, done;
   logic [15:0] read_address;
   logic [3:0]  rom_data;

   int errors = 0;
   int checks = 0;

   int r_npix, r_bad_data, r_bad_eol, r_bad_eof, r_stall_bad, r_max_out;
   int r_first_valid, r_done_k, r_eof_k, r_done, r_busy, r_timeout;
   int r_busy_after, r_valid_after;
   int addr_log[$];
   int small_exp[6] = '{4490, 4491, 4492, 4714, 4715, 4716};

   end_screen_reader_if #(.PIX_W(4)) pix_if ();

   end_screen_reader #(
      .FIFO_DEPTH (4)
   ) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .start        (start),
      .abort        (abort),
      .win_x        (win_x),
      .win_y        (win_y),
      .win_w        (win_w),
      .win_h        (win_h),
      .busy         (busy),
      .done         (done),
      .read_address (read_address),
      .rom_data     (rom_data),
      .pix          (pix_if)
   );

   always #5 Clk = ~Clk;

   function automatic logic [3:0] rom_img(input int a);
      return 4'(a ^ (a >> 4) ^ (a >> 9));
   endfunction

   always @(posedge Clk) rom_data <= rom_img(int'(read_address));

   task automatic check_eq(input string tag, input int got, input int exp);
      checks++;
      if (got != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
      end
   endtask

   // mode 0: always ready; mode 1: ready pattern 1,0,0,1.
   task automatic run_window(input int x, input int y, input int w, input int h,
                             input int ew, input int eh, input int mode,
                             input int abort_at);
      int total, budget, k, prev_addr, post, r, c, a, outst;
      bit prev_stall, aborted, finished, rdy;
      logic [3:0] prev_data;
      logic prev_eol, prev_eof;
      total = ew * eh;
      budget = total * 6 + 64;
      r_npix = 0; r_bad_data = 0; r_bad_eol = 0; r_bad_eof = 0;
      r_stall_bad = 0; r_max_out = 0; r_first_valid = -1; r_done_k = -1;
      r_eof_k = -1; r_done = 0; r_busy = 0; r_timeout = 0;
      r_busy_after = -1; r_valid_after = -1;
      addr_log.delete();
      prev_stall = 0; aborted = 0; finished = 0; post = 0;
      prev_data = '0; prev_eol = 0; prev_eof = 0;
      win_x = 8'(x); win_y = 8'(y); win_w = 8'(w); win_h = 9'(h);
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      k = 1;
      prev_addr = int'(read_address);
      while (!finished) begin
         if (int'(read_address) != prev_addr) begin
            prev_addr = int'(read_address);
            addr_log.push_back(prev_addr);
         end
         if (busy) r_busy++;
         if (done) begin r_done++; r_done_k = k; end
         if (pix_if.pix_valid && r_first_valid < 0) r_first_valid = k;
         if (prev_stall && (!pix_if.pix_valid || pix_if.pix_data != prev_data ||
                            pix_if.pix_eol != prev_eol || pix_if.pix_eof != prev_eof))
            r_stall_bad++;
         outst = addr_log.size() - r_npix;
         if (outst > r_max_out) r_max_out = outst;
         rdy = (mode == 1) ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
         pix_if.pix_ready = rdy;
         start = (k == 5) && (total != 0);
         if (pix_if.pix_valid && rdy) begin
            if (r_npix < total) begin
               r = r_npix / ew;
               c = r_npix % ew;
               a = (y + r) * 224 + x + c;
               if (pix_if.pix_data != rom_img(a)) r_bad_data++;
               if (pix_if.pix_eol != (c == ew - 1)) r_bad_eol++;
               if (pix_if.pix_eof != (r_npix == total - 1)) r_bad_eof++;
            end else begin
               r_bad_data++;
            end
            if (pix_if.pix_eof) r_eof_k = k;
            r_npix++;
         end
         prev_stall = pix_if.pix_valid && !rdy;
         prev_data = pix_if.pix_data;
         prev_eol = pix_if.pix_eol;
         prev_eof = pix_if.pix_eof;
         if (abort_at > 0 && r_npix == abort_at && !aborted) begin
            abort = 1'b1;
            aborted = 1;
         end
         @(negedge Clk);
         k++;
         if (abort) begin
            r_busy_after = int'(busy);
            r_valid_after = int'(pix_if.pix_valid);
            abort = 1'b0;
         end
         if (r_done_k >= 0 || aborted) post++;
         if (post >= 4) finished = 1;
         if (k > budget) begin
            r_timeout = 1;
            finished = 1;
         end
      end
      start = 1'b0;
      pix_if.pix_ready = 1'b1;
   endtask

   task automatic check_idle_outputs(input string pfx);
      check_eq({pfx, "_busy"}, int'(busy), 0);
      check_eq({pfx, "_done"}, int'(done), 0);
      check_eq({pfx, "_valid"}, int'(pix_if.pix_valid), 0);
      check_eq({pfx, "_eol"}, int'(pix_if.pix_eol), 0);
      check_eq({pfx, "_eof"}, int'(pix_if.pix_eof), 0);
      check_eq({pfx, "_addr"}, int'(read_address), 0);
      check_eq({pfx, "_data"}, int'(pix_if.pix_data), 0);
   endtask

   initial begin
      Reset_n = 1'b1; start = 1'b0; abort = 1'b0;
      win_x = '0; win_y = '0; win_w = '0; win_h = '0;
      pix_if.pix_ready = 1'b0;
      #2 Reset_n = 1'b0;
      @(negedge Clk);
      check_idle_outputs("rst");
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);

      run_window(10, 20, 3, 2, 3, 2, 0, 0);
      check_eq("small_timeout", r_timeout, 0);
      check_eq("small_npix", r_npix, 6);
      check_eq("small_naddr", addr_log.size(), 6);
      for (int i = 0; i < 6; i++)
         check_eq($sformatf("small_addr%0d", i),
                  (i < addr_log.size()) ? addr_log[i] : -1, small_exp[i]);
      check_eq("small_data", r_bad_data, 0);
      check_eq("small_eol", r_bad_eol, 0);
      check_eq("small_eof", r_bad_eof, 0);
      check_eq("small_first_valid", r_first_valid, 4);
      check_eq("small_done_cnt", r_done, 1);
      check_eq("small_done_lat", r_done_k - r_eof_k, 1);

      run_window(30, 40, 8, 8, 8, 8, 1, 0);
      check_eq("bp_timeout", r_timeout, 0);
      check_eq("bp_npix", r_npix, 64);
      check_eq("bp_data", r_bad_data, 0);
      check_eq("bp_eol", r_bad_eol, 0);
      check_eq("bp_eof", r_bad_eof, 0);
      check_eq("bp_stall_stable", r_stall_bad, 0);
      check_eq("bp_max_out_le4", int'(r_max_out <= 4), 1);
      check_eq("bp_done_cnt", r_done, 1);
      check_eq("bp_done_lat", r_done_k - r_eof_k, 1);

      run_window(220, 250, 10, 10, 4, 6, 0, 0);
      check_eq("clip_npix", r_npix, 24);
      check_eq("clip_data", r_bad_data, 0);
      check_eq("clip_eol", r_bad_eol, 0);
      check_eq("clip_eof", r_bad_eof, 0);
      check_eq("clip_last_addr", (addr_log.size() > 0) ? addr_log[$] : -1, 57343);
      check_eq("clip_done_cnt", r_done, 1);

      run_window(5, 5, 0, 5, 0, 5, 0, 0);
      check_eq("empty_npix", r_npix, 0);
      check_eq("empty_naddr", addr_log.size(), 0);
      check_eq("empty_done_k", r_done_k, 1);
      check_eq("empty_done_cnt", r_done, 1);
      check_eq("empty_busy_cycles", r_busy, 1);

      run_window(0, 0, 224, 256, 224, 256, 0, 0);
      check_eq("full_timeout", r_timeout, 0);
      check_eq("full_npix", r_npix, 57344);
      check_eq("full_data", r_bad_data, 0);
      check_eq("full_eol", r_bad_eol, 0);
      check_eq("full_eof", r_bad_eof, 0);
      check_eq("full_first_valid", r_first_valid, 4);
      check_eq("full_done_cnt", r_done, 1);
      check_eq("full_done_lat", r_done_k - r_eof_k, 1);

      run_window(0, 0, 224, 256, 224, 256, 0, 100);
      check_eq("abort_npix", r_npix, 100);
      check_eq("abort_data", r_bad_data, 0);
      check_eq("abort_busy_after", r_busy_after, 0);
      check_eq("abort_valid_after", r_valid_after, 0);
      check_eq("abort_no_done", r_done, 0);
      run_window(0, 0, 16, 2, 16, 2, 0, 0);
      check_eq("restart_npix", r_npix, 32);
      check_eq("restart_data", r_bad_data, 0);
      check_eq("restart_eof", r_bad_eof, 0);
      check_eq("restart_first_valid", r_first_valid, 4);
      check_eq("restart_done_cnt", r_done, 1);

      win_x = 8'd0; win_y = 8'd0; win_w = 8'd224; win_h = 9'd256;
      start = 1'b1;
      @(negedge Clk);
      start = 1'b0;
      pix_if.pix_ready = 1'b1;
      repeat (40) @(negedge Clk);
      check_eq("mid_busy_pre", int'(busy), 1);
      check_eq("mid_valid_pre", int'(pix_if.pix_valid), 1);
      Reset_n = 1'b0;
      #1;
      check_idle_outputs("midrst");
      @(negedge Clk);
      Reset_n = 1'b1;
      @(negedge Clk);
      check_eq("midrst_busy_post", int'(busy), 0);
      run_window(10, 20, 3, 2, 3, 2, 0, 0);
      check_eq("post_rst_npix", r_npix, 6);
      check_eq("post_rst_data", r_bad_data, 0);
      check_eq("post_rst_addr0", (addr_log.size() > 0) ? addr_log[0] : -1, 4490);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
